ftoi_pipe: RTL

Converts an IEEE-754 binary32 value to a signed 32-bit two's-complement integer.
- Rounding is round-to-nearest, ties away from zero. This matches the half-LSB increment rounding used by the int-to-float path.
- Out-of-range values saturate.
- It is a 2-stage pipeline with valid/ready handshakes on both sides, so it can sit between the FPU operand bus and the integer writeback path under backpressure.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/ftoi_align.sv | 58 +++++
 rtl/ftoi_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and types shared by the float/int conversion datapath.
//   EXP_BIAS / EXP_MAX     binary32 exponent bias and all-ones exponent
//   INT32_MAX / INT32_MIN  saturation values for signed 32-bit results
//   EXP_HALF / EXP_SAT     exponent of 0.5 and of 2^31 (conversion range edges)
//   ftoi_class             operand class computed before the stage-1 registers
package fpu_pkg;
   localparam int          EXP_BIAS  = 127;
   localparam int          EXP_MAX   = 255;
   localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   // Below EXP_HALF the magnitude is < 0.5 and rounds to 0.
   // At or above EXP_SAT the magnitude is >= 2^31 and does not fit.
   localparam logic [7:0]  EXP_HALF  = 8'(EXP_BIAS - 1);
   localparam logic [7:0]  EXP_SAT   = 8'(EXP_BIAS + 31);
   localparam logic [7:0]  EXP_ONES  = 8'(EXP_MAX);

   typedef enum logic [2:0] {
      ZERO      = 3'd0,
      NORM      = 3'd1,
      SAT_POS   = 3'd2,
      SAT_NEG   = 3'd3,
      EXACT_MIN = 3'd4
   } ftoi_class;
endpackage

// File: rtl/ftoi_align.sv
// ftoi_align: combinational front end of the float-to-int converter.
// Classifies the binary32 operand and right-aligns its significand so the
// integer part lands in bit 0 upward.
//   x          in   binary32 operand {sign, exp[7:0], frac[22:0]}
//   cls        out  operand class
//   mag_trunc  out  integer part of |x| (valid for NORM, else 0)
//   guard      out  first bit below the integer point (valid for NORM, else 0)
module ftoi_align
   import fpu_pkg::*;
(
   input  logic [31:0] x,
   output ftoi_class   cls,
   output logic [30:0] mag_trunc,
   output logic        guard
);

   logic        sign;
   logic [7:0]  expo;
   logic [22:0] frac;
   logic [31:0] a_val;
   logic [5:0]  sh;
   logic [4:0]  guard_idx;

   assign sign  = x[31];
   assign expo  = x[30:23];
   assign frac  = x[22:0];

   // Significand placed so that bit 31 is the hidden one; a shift of
   // (158 - e) then leaves the integer part in the low bits.
   assign a_val     = {1'b1, frac, 8'b0};
   assign sh        = 6'(EXP_SAT - expo);
   assign guard_idx = 5'(sh - 6'd1);

   always_comb begin
      cls       = ZERO;
      mag_trunc = '0;
      guard     = 1'b0;
      if (expo < EXP_HALF) begin
         cls = ZERO;
      end else if (expo == EXP_ONES) begin
         // NaN always saturates positive; Inf follows its sign.
         cls = ((frac != '0) || !sign) ? SAT_POS : SAT_NEG;
      end else if (expo >= EXP_SAT) begin
         // -2^31 is the only value at or beyond 2^31 that still fits.
         if (sign && (expo == EXP_SAT) && (frac == '0))
            cls = EXACT_MIN;
         else
            cls = sign ? SAT_NEG : SAT_POS;
      end else begin
         cls = NORM;
         // sh is 1..32; a shift by 32 clears the value, leaving the hidden
         // one as the guard bit (0.5 <= |x| < 1 rounds to 1).
         mag_trunc = 31'(a_val >> sh);
         guard     = a_val[guard_idx];
      end
   end

endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage binary32 -> signed int32 converter, rounding to
// nearest with ties away from zero, saturating out-of-range inputs.
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   in_valid   in   x carries a conversion request
//   in_ready   out  x is accepted this cycle
//   x          in   binary32 operand
//   out_valid  out  y/ovf hold a result
//   out_ready  in   consumer takes y this cycle
//   y          out  signed integer result
//   ovf        out  result saturated (out of range, Inf or NaN)
module ftoi_pipe
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        ovf
);

   ftoi_class   align_cls;
   logic [30:0] align_mag;
   logic        align_guard;

   ftoi_align u_align (
      .x         (x),
      .cls       (align_cls),
      .mag_trunc (align_mag),
      .guard     (align_guard)
   );

   logic        s1_valid_q, s1_valid_d;
   logic        s1_sign_q,  s1_sign_d;
   ftoi_class   s1_cls_q,   s1_cls_d;
   logic [30:0] s1_mag_q,   s1_mag_d;
   logic        s1_guard_q, s1_guard_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] y_q, y_d;
   logic        ovf_q, ovf_d;

   logic        s2_load;
   logic [31:0] rounded;

   // Stage 1 can take a new operand unless both stages are full and the
   // consumer is stalling.
   assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   // Cannot carry out of bit 30: the largest truncated magnitude has a zero guard.
   assign rounded  = {1'b0, s1_mag_q} + {31'b0, s1_guard_q};

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_cls_d    = s1_cls_q;
      s1_mag_d    = s1_mag_q;
      s1_guard_d  = s1_guard_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      ovf_d       = ovf_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         // Data registers only move on a real transfer.
         if (in_valid) begin
            s1_sign_d  = x[31];
            s1_cls_d   = align_cls;
            s1_mag_d   = align_mag;
            s1_guard_d = align_guard;
         end
      end

      if (s2_load) begin
         out_valid_d = 1'b1;
         case (s1_cls_q)
            NORM: begin
               y_d   = s1_sign_q ? (~rounded + 32'd1) : rounded;
               ovf_d = 1'b0;
            end
            SAT_POS: begin
               y_d   = INT32_MAX;
               ovf_d = 1'b1;
            end
            SAT_NEG: begin
               y_d   = INT32_MIN;
               ovf_d = 1'b1;
            end
            EXACT_MIN: begin
               y_d   = INT32_MIN;
               ovf_d = 1'b0;
            end
            default: begin
               y_d   = '0;
               ovf_d = 1'b0;
            end
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_cls_q    <= ZERO;
         s1_mag_q    <= '0;
         s1_guard_q  <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_cls_q    <= s1_cls_d;
         s1_mag_q    <= s1_mag_d;
         s1_guard_q  <= s1_guard_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign ovf       = ovf_q;

endmodule
